// File: rtl/nbj_correct_sender.sv
// Clocked two-phase (toggle) sender for the 37-bit branch-correction packet, fed from a small FIFO.
// Optional flush port enabled by defining NBJ_CORRECT_SENDER_FLUSH_EN.
module nbj_correct_sender #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_record_only,
  input  logic        i_type,
  input  logic [2:0]  i_index_3,
  input  logic [31:0] i_pc_32,
  output logic        o_drive,
  output logic [36:0] o_data_37,
  input  logic        i_free,
`ifdef NBJ_CORRECT_SENDER_FLUSH_EN
  input  logic        i_flush,
`endif
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [36:0]            r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_free_seen;
  logic                   r_drive;
  logic [36:0]            r_data;
  state_t                 r_state;

  logic        w_flush;
  logic        w_push;
  logic        w_pop;
  logic        w_free_s;
  logic        w_ack;
  logic [36:0] w_word;

`ifdef NBJ_CORRECT_SENDER_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_word   = {i_record_only, i_type, i_index_3, i_pc_32};
  assign o_ready  = (r_count != CW'(DEPTH));
  assign w_push   = i_valid & o_ready & ~w_flush;
  assign w_pop    = (r_state == S_IDLE) & (r_count != '0) & ~w_flush;
  assign w_free_s = r_sync[SYNC_STAGES-1];
  // Acknowledge toggles outside WAIT are protocol errors and simply not consumed.
  assign w_ack    = (r_state == S_WAIT) & (w_free_s != r_free_seen);

  assign o_drive   = r_drive;
  assign o_data_37 = r_data;
  assign o_busy    = (r_state != S_IDLE) | (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_free};
    end
  end

  // Data is loaded one cycle before the drive toggle so it is settled when the receiver sees the request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_drive     <= 1'b0;
      r_data      <= '0;
      r_free_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data  <= r_mem[r_rd_ptr];
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_drive <= ~r_drive;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_ack) begin
            r_free_seen <= w_free_s;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
